// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Groups the MEM-stage request/response signals of the data-memory
//   responder into one bundle.
//
//   Request side (driven by the pipeline / master):
//     ena      request valid, held until ack
//     wena     1 = store, 0 = load
//     w_cs     store size (00 word, 01 half, 10 byte, 11 word)
//     r_cs     load size, same encoding
//     addr     byte address
//     data_in  store data, right-aligned
//   Response side (driven by the responder / slave):
//     data_out load data, right-aligned, zero-extended
//     ack      one-cycle completion pulse
//     err      misaligned access flag, only meaningful with ack
//     stall    combinational ena & ~ack back to the pipeline
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        ena;
  logic        wena;
  logic [1:0]  w_cs;
  logic [1:0]  r_cs;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output ena, wena, w_cs, r_cs, addr, data_in,
    input  data_out, ack, err, stall
  );

  modport slave (
    input  ena, wena, w_cs, r_cs, addr, data_in,
    output data_out, ack, err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the MEM stage of the static pipeline. Accepts
//   one load/store at a time, models WAIT_CYCLES of access latency and then
//   pulses ack for one cycle, returning zero-extended read data. Misaligned
//   accesses complete with err set, never write the array and return zero.
//
// Parameters
//   ADDR_W       word-address bits, array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  extra cycles between acceptance and ack (0..15)
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   dmem_responder_if.slave: ena/wena/w_cs/r_cs/addr/data_in in,
//         data_out/ack/err/stall out
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the byte-address bits that reach the array are ever kept; the rest
  // of the address is ignored, which gives the aliasing wrap-around.
  localparam int         LA        = ADDR_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            wena_q;
  logic [1:0]      size_q;
  logic [LA-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem_q [2**ADDR_W];

  logic            accept;
  logic            enter_done;

  logic            cur_wena;
  logic [1:0]      cur_size;
  logic [LA-1:0]   cur_addr;
  logic [31:0]     cur_wdata;

  logic [ADDR_W-1:0] idx;
  logic [1:0]      lane;
  logic            is_half;
  logic            is_byte;
  logic            is_word;
  logic            misaligned;
  logic [31:0]     rd_word;
  logic [31:0]     rd_data;
  logic [31:0]     wr_lanes;
  logic [3:0]      byte_en;

  logic            addr_unused_hi;

  assign addr_unused_hi = ^bus.addr[31:LA];

  // The access that completes on the edge into DONE is described by the
  // latched request, except when WAIT_CYCLES is zero: then DONE is entered on
  // the acceptance edge itself and the live inputs are the request.
  always_comb begin
    cur_wena  = wena_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      cur_wena  = bus.wena;
      cur_size  = bus.wena ? bus.w_cs : bus.r_cs;
      cur_addr  = bus.addr[LA-1:0];
      cur_wdata = bus.data_in;
    end
  end

  // Next-state logic. The wait counter is loaded with WAIT_CYCLES on
  // acceptance; the decrement that would reach zero is the same edge that
  // moves into DONE, so ack appears WAIT_CYCLES+1 cycles after the request
  // first went valid.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ena) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Size decode, alignment check and little-endian lane steering for both
  // the read path (extract and zero-extend) and the write path (replicate
  // store data across lanes, enable only the addressed ones).
  always_comb begin
    idx        = cur_addr[LA-1:2];
    lane       = cur_addr[1:0];
    is_half    = (cur_size == 2'b01);
    is_byte    = (cur_size == 2'b10);
    is_word    = !is_half && !is_byte;
    misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    rd_word    = mem_q[idx];
    rd_data    = rd_word;
    wr_lanes   = cur_wdata;
    byte_en    = 4'b1111;
    if (is_byte) begin
      wr_lanes = {4{cur_wdata[7:0]}};
      case (lane)
        2'd0:    begin rd_data = {24'b0, rd_word[7:0]};   byte_en = 4'b0001; end
        2'd1:    begin rd_data = {24'b0, rd_word[15:8]};  byte_en = 4'b0010; end
        2'd2:    begin rd_data = {24'b0, rd_word[23:16]}; byte_en = 4'b0100; end
        default: begin rd_data = {24'b0, rd_word[31:24]}; byte_en = 4'b1000; end
      endcase
    end else if (is_half) begin
      wr_lanes = {2{cur_wdata[15:0]}};
      if (lane[1]) begin
        rd_data = {16'b0, rd_word[31:16]};
        byte_en = 4'b1100;
      end else begin
        rd_data = {16'b0, rd_word[15:0]};
        byte_en = 4'b0011;
      end
    end
  end

  // State, request latch and registered response. Reset abandons whatever
  // request is pending; ack/err/data_out only ever change on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wena_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wena_q  <= bus.wena;
        size_q  <= bus.wena ? bus.w_cs : bus.r_cs;
        addr_q  <= bus.addr[LA-1:0];
        wdata_q <= bus.data_in;
      end
      ack_q <= enter_done;
      err_q <= enter_done && misaligned;
      if (enter_done) begin
        rdata_q <= (cur_wena || misaligned) ? 32'd0 : rd_data;
      end
    end
  end

  // The array itself has no reset. A store commits only on the edge into
  // DONE, so a reset arriving earlier (or on that same edge) drops it.
  always_ff @(posedge clk) begin
    if (!rst && enter_done && cur_wena && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
        end
      end
    end
  end

  assign bus.data_out = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.stall    = bus.ena & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Three responders (WAIT_CYCLES 0, 1, 3) share one clock and reset; the
//   bench steers a single request port to whichever one is selected and
//   compares every completion against a word-array model of the memory.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        reqEna;
  logic        reqWena;
  logic [1:0]  reqWcs;
  logic [1:0]  reqRcs;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  int          sel;

  logic        ack;
  logic        err;
  logic        stall;
  logic [31:0] dataOut;

  int passCount;
  int checkCount;

  int          waitOf [3];
  logic [31:0] model [3][2048];

  dmem_responder_if ifc0 ();
  dmem_responder_if ifc1 ();
  dmem_responder_if ifc2 ();

  dmem_responder #(.ADDR_W(11), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  dmem_responder #(.ADDR_W(11), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
  dmem_responder #(.ADDR_W(11), .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

  // Only the selected responder sees ena; the rest of the request is shared.
  assign ifc0.ena = reqEna && (sel == 0);
  assign ifc1.ena = reqEna && (sel == 1);
  assign ifc2.ena = reqEna && (sel == 2);
  assign ifc0.wena = reqWena;  assign ifc1.wena = reqWena;  assign ifc2.wena = reqWena;
  assign ifc0.w_cs = reqWcs;   assign ifc1.w_cs = reqWcs;   assign ifc2.w_cs = reqWcs;
  assign ifc0.r_cs = reqRcs;   assign ifc1.r_cs = reqRcs;   assign ifc2.r_cs = reqRcs;
  assign ifc0.addr = reqAddr;  assign ifc1.addr = reqAddr;  assign ifc2.addr = reqAddr;
  assign ifc0.data_in = reqData; assign ifc1.data_in = reqData; assign ifc2.data_in = reqData;

  // Response of the currently selected responder.
  always_comb begin
    ack = ifc0.ack; err = ifc0.err; stall = ifc0.stall; dataOut = ifc0.data_out;
    if (sel == 1) begin
      ack = ifc1.ack; err = ifc1.err; stall = ifc1.stall; dataOut = ifc1.data_out;
    end else if (sel == 2) begin
      ack = ifc2.ack; err = ifc2.err; stall = ifc2.stall; dataOut = ifc2.data_out;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Reference behaviour: byte-addressed little-endian memory of 32-bit words,
  // address taken modulo the array size, misaligned accesses do nothing.
  task automatic modelAccess(input int k, input bit st, input logic [1:0] size,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] expDout, output logic expErr);
    int          wIdx;
    int          byteOff;
    logic [31:0] w;
    bit          isHalf;
    bit          isByte;
    wIdx    = int'((a >> 2) % 2048);
    byteOff = int'(a % 4);
    isHalf  = (size == 2'd1);
    isByte  = (size == 2'd2);
    expErr  = isHalf ? (byteOff % 2 != 0) : (!isByte && byteOff != 0);
    expDout = 32'd0;
    w       = model[k][wIdx];
    if (!expErr) begin
      if (st) begin
        if (isByte)      w[byteOff*8 +: 8]   = d[7:0];
        else if (isHalf) w[byteOff*8 +: 16]  = d[15:0];
        else             w                   = d;
        model[k][wIdx] = w;
      end else begin
        if (isByte)      expDout = (w >> (byteOff*8)) & 32'h0000_00FF;
        else if (isHalf) expDout = (w >> (byteOff*8)) & 32'h0000_FFFF;
        else             expDout = w;
      end
    end
  endtask

  // Drive one request on the selected responder and wait (bounded) for ack.
  // After acceptance the request inputs are scrambled, and optionally ena is
  // dropped, to show that only the latched request matters.
  task automatic applyStimulus(input int k, input bit st, input logic [1:0] size,
                               input logic [31:0] a, input logic [31:0] d, input bit dropEna,
                               output logic [31:0] dout, output logic e,
                               output int stallCycles, output bit gotAck);
    @(negedge clk);
    sel     = k;
    reqEna  = 1'b1;
    reqWena = st;
    reqWcs  = st ? size : 2'($urandom);
    reqRcs  = st ? 2'($urandom) : size;
    reqAddr = a;
    reqData = d;
    stallCycles = 0;
    gotAck  = 1'b0;
    dout    = 32'd0;
    e       = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ack) begin
        gotAck = 1'b1;
        dout   = dataOut;
        e      = err;
        break;
      end
      if (stall) stallCycles++;
      @(negedge clk);
      if (c == 0) begin
        reqWena = 1'($urandom);
        reqWcs  = 2'($urandom);
        reqRcs  = 2'($urandom);
        reqAddr = $urandom;
        reqData = $urandom;
        if (dropEna) reqEna = 1'b0;
      end
    end
    reqEna = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("ackPulseOnce", {31'd0, ack}, 32'd0);
    checkOutput("errIdle", {31'd0, err}, 32'd0);
  endtask

  task automatic runTransaction(input int k, input bit st, input logic [1:0] size,
                                input logic [31:0] a, input logic [31:0] d, input bit dropEna,
                                output logic [31:0] dout, output logic e);
    logic [31:0] expDout;
    logic        expErr;
    int          stallCycles;
    bit          gotAck;
    modelAccess(k, st, size, a, d, expDout, expErr);
    applyStimulus(k, st, size, a, d, dropEna, dout, e, stallCycles, gotAck);
    checkOutput("ackSeen", {31'd0, gotAck}, 32'd1);
    checkOutput("err", {31'd0, e}, {31'd0, expErr});
    checkOutput("dataOut", dout, expDout);
    if (!dropEna) checkOutput("stallCycles", stallCycles, waitOf[k] + 1);
  endtask

  initial begin
    logic [31:0] dout;
    logic        e;
    bit          sawAck;
    passCount = 0;
    checkCount = 0;
    waitOf = '{0, 1, 3};
    sel = 0; reqEna = 1'b0; reqWena = 1'b0; reqWcs = 2'b00; reqRcs = 2'b00;
    reqAddr = 32'd0; reqData = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstAck0", {31'd0, ifc0.ack}, 32'd0);
    checkOutput("rstAck1", {31'd0, ifc1.ack}, 32'd0);
    checkOutput("rstAck2", {31'd0, ifc2.ack}, 32'd0);
    checkOutput("rstErr1", {31'd0, ifc1.err}, 32'd0);
    checkOutput("rstData0", ifc0.data_out, 32'd0);
    checkOutput("rstData2", ifc2.data_out, 32'd0);
    checkOutput("rstStall1", {31'd0, ifc1.stall}, 32'd0);
    rst = 1'b0;

    // Give every word the bench will touch a known value.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 32; w++)
        runTransaction(k, 1'b1, 2'b00, 32'(w * 4), 32'd0, 1'b0, dout, e);

    // Word store / load, WAIT_CYCLES = 1.
    runTransaction(1, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, dout, e);
    runTransaction(1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, dout, e);
    checkOutput("t1LoadWord", dout, 32'hDEADBEEF);

    // Byte stores assemble a little-endian word.
    runTransaction(1, 1'b1, 2'b10, 32'h20, 32'hFFFFFF11, 1'b0, dout, e);
    runTransaction(1, 1'b1, 2'b10, 32'h21, 32'h00000022, 1'b0, dout, e);
    runTransaction(1, 1'b1, 2'b10, 32'h22, 32'hABCDEF33, 1'b0, dout, e);
    runTransaction(1, 1'b1, 2'b10, 32'h23, 32'h00000044, 1'b0, dout, e);
    runTransaction(1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0, dout, e);
    checkOutput("t2LoadWord", dout, 32'h44332211);
    runTransaction(1, 1'b0, 2'b10, 32'h22, 32'h0, 1'b0, dout, e);
    checkOutput("t2LoadByte", dout, 32'h00000033);

    // Upper-half store keeps the lower half.
    runTransaction(1, 1'b1, 2'b00, 32'h30, 32'h12345678, 1'b0, dout, e);
    runTransaction(1, 1'b1, 2'b01, 32'h32, 32'h9999ABCD, 1'b0, dout, e);
    runTransaction(1, 1'b0, 2'b11, 32'h30, 32'h0, 1'b0, dout, e);
    checkOutput("t3LoadWord", dout, 32'hABCD5678);
    runTransaction(1, 1'b0, 2'b01, 32'h32, 32'h0, 1'b0, dout, e);
    checkOutput("t3LoadHalf", dout, 32'h0000ABCD);

    // Misaligned accesses.
    runTransaction(1, 1'b1, 2'b00, 32'h41, 32'hFFFFFFFF, 1'b0, dout, e);
    checkOutput("t4StoreErr", {31'd0, e}, 32'd1);
    runTransaction(1, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, dout, e);
    checkOutput("t4WordKept", dout, 32'h00000000);
    runTransaction(1, 1'b0, 2'b01, 32'h43, 32'h0, 1'b0, dout, e);
    checkOutput("t4LoadErr", {31'd0, e}, 32'd1);
    checkOutput("t4LoadData", dout, 32'h00000000);

    // Aliasing on the zero- and three-wait responders.
    runTransaction(0, 1'b1, 2'b00, 32'h2000, 32'h5A5A1234, 1'b0, dout, e);
    runTransaction(0, 1'b0, 2'b00, 32'h0000, 32'h0, 1'b0, dout, e);
    checkOutput("t5Alias0", dout, 32'h5A5A1234);
    runTransaction(2, 1'b1, 2'b00, 32'h2000, 32'hC3C3A5A5, 1'b0, dout, e);
    runTransaction(2, 1'b0, 2'b00, 32'h0000, 32'h0, 1'b0, dout, e);
    checkOutput("t5Alias2", dout, 32'hC3C3A5A5);

    // Reset in the middle of a store's wait.
    @(negedge clk);
    sel = 2; reqEna = 1'b1; reqWena = 1'b1; reqWcs = 2'b00;
    reqAddr = 32'h50; reqData = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    checkOutput("t6NoAckYet", {31'd0, ack}, 32'd0);
    rst = 1'b1;
    reqEna = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("t6RstAck", {31'd0, ack}, 32'd0);
    checkOutput("t6RstErr", {31'd0, err}, 32'd0);
    checkOutput("t6RstData", dataOut, 32'd0);
    rst = 1'b0;
    sawAck = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (ack) sawAck = 1'b1;
    end
    checkOutput("t6NoAckAfter", {31'd0, sawAck}, 32'd0);
    runTransaction(2, 1'b0, 2'b00, 32'h50, 32'h0, 1'b0, dout, e);
    checkOutput("t6WordKept", dout, 32'h00000000);

    // Random traffic over a small window with random aliasing bits.
    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [31:0] a;
      k = int'($urandom_range(0, 2));
      a = ($urandom << 13) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      runTransaction(k, 1'($urandom), 2'($urandom), a, $urandom,
                     ($urandom_range(0, 7) == 0), dout, e);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
